// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the digits shown on a multiplexed 4-digit,
// active-low 7-segment display and presents them as 16-bit frames.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   seg_n[6:0]   active-low segments {g,f,e,d,c,b,a}
//   dig_en_n[3:0] active-low digit enables; bit i selects digit i
//   frame_data   decoded nibbles, digit i in [4i+3:4i]
//   frame_err    bit i set when digit i held an unrecognised glyph
//   frame_valid  a complete frame is held on frame_data/frame_err
//   frame_ready  consumer accepts the frame on frame_valid & frame_ready
//   overrun      sticky; set when a completed frame had to be dropped
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_en_n,
  output logic [15:0] frame_data,
  output logic [3:0]  frame_err,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  // Sample stage and the previous sample used for stability comparison
  logic [6:0] seg_q;
  logic [3:0] dig_q;
  logic [6:0] seg_p;
  logic [3:0] dig_p;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             capture_c;
  logic             match_c;
  logic             onehot_c;

  logic [3:0]  dec_nib_c;
  logic        dec_err_c;
  logic [3:0]  cap_mask_c;

  logic [15:0] asm_data;
  logic [3:0]  asm_err;
  logic [3:0]  seen;
  logic        load_c;
  logic        drop_c;

  // Input register followed by the one-sample history
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= '0;
      dig_q <= '0;
      seg_p <= '0;
      dig_p <= '0;
    end else begin
      seg_q <= seg_n;
      dig_q <= dig_en_n;
      seg_p <= seg_q;
      dig_p <= dig_q;
    end
  end

  assign match_c   = (seg_q == seg_p) && (dig_q == dig_p);
  assign onehot_c  = $onehot(~dig_q);
  assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // FSM state and stability counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state: capture fires once, on the cycle the counter reaches its limit
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    capture_c = 1'b0;
    if (!onehot_c) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        CAPTURED: begin
          if (!match_c) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: begin
          cnt_d = match_c ? cnt_inc_c : '0;
          if (cnt_d == CNT_MAX) begin
            capture_c = 1'b1;
            state_d   = CAPTURED;
          end else begin
            state_d = SETTLE;
          end
        end
      endcase
    end
  end

  // Glyph decode of the sampled segment pattern
  always_comb begin
    dec_nib_c = 4'h0;
    dec_err_c = 1'b0;
    case (seg_q)
      7'b1000000: dec_nib_c = 4'h0;
      7'b1111001: dec_nib_c = 4'h1;
      7'b0100100: dec_nib_c = 4'h2;
      7'b0110000: dec_nib_c = 4'h3;
      7'b0011001: dec_nib_c = 4'h4;
      7'b0010010: dec_nib_c = 4'h5;
      7'b0000010: dec_nib_c = 4'h6;
      7'b1111000: dec_nib_c = 4'h7;
      7'b0000000: dec_nib_c = 4'h8;
      7'b0010000: dec_nib_c = 4'h9;
      7'b0001000: dec_nib_c = 4'hA;
      7'b0000011: dec_nib_c = 4'hB;
      7'b1000110: dec_nib_c = 4'hC;
      7'b0100001: dec_nib_c = 4'hD;
      7'b0000110: dec_nib_c = 4'hE;
      7'b0001110: dec_nib_c = 4'hF;
      default:    dec_err_c = 1'b1;
    endcase
  end

  // Active-high one-hot slot select; zero when nothing is captured
  assign cap_mask_c = capture_c ? ~dig_q : 4'h0;
  assign load_c     = (seen == 4'hF);
  assign drop_c     = load_c && frame_valid && !frame_ready;

  // Assembly buffer; a full seen mask is consumed the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_data <= '0;
      asm_err  <= '0;
      seen     <= '0;
    end else begin
      seen <= (load_c ? 4'h0 : seen) | cap_mask_c;
      for (int i = 0; i < 4; i++) begin
        if (cap_mask_c[i]) begin
          asm_data[4*i +: 4] <= dec_nib_c;
          asm_err[i]         <= dec_err_c;
        end
      end
    end
  end

  // Output frame holding register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data  <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (load_c) begin
      if (drop_c) begin
        overrun <= 1'b1;
      end else begin
        frame_data  <= asm_data;
        frame_err   <= asm_err;
        frame_valid <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
